// File: rtl/condicionador_chaves_pkg.sv
// ============================================================================
// condicionador_chaves_pkg : switch bit map and defaults for the input conditioner
// Rev 1.0
// ============================================================================
`default_nettype none

package condicionador_chaves_pkg;

   localparam int SW_CLEAR  = 0;
   localparam int SW_DOWN   = 1;
   localparam int SW_STEP3  = 2;
   localparam int SW_FREEZE = 3;
   localparam int SW_SAT    = 4;

   localparam int NBITS_SW_DEF        = 5;
   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int TICK_DIV_DEF        = 4;

   // A counter that only ever holds 0 still needs one flop.
   function automatic int width_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_bit.sv
// ============================================================================
// debounce_bit : two-flop synchroniser plus hold-time debouncer for one switch
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_bit
   import condicionador_chaves_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic clean_o,
   output logic rise_next_o
);

   localparam int              CW       = width_min1(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          clean_q;
   logic          clean_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      clean_d = clean_q;
      cnt_d   = cnt_q;
      if (sync2_q == clean_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         clean_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         clean_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         clean_q <= clean_d;
         cnt_q   <= cnt_d;
      end
   end

   assign clean_o = clean_q;
   // High in the cycle whose closing edge commits a 0->1 change of the clean level.
   assign rise_next_o = ~clean_q & clean_d;

endmodule

`default_nettype wire

// File: rtl/condicionador_chaves.sv
// ============================================================================
// condicionador_chaves : debounced switch levels, rise pulses and count-enable tick
// Rev 1.0
// ============================================================================
`default_nettype none

module condicionador_chaves
   import condicionador_chaves_pkg::*;
#(
   parameter int NBITS_SW        = NBITS_SW_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int TICK_DIV        = TICK_DIV_DEF
)(
   input  logic                clk_2,
   input  logic                reset_n,
   input  logic [NBITS_SW-1:0] sw_raw,
   output logic [NBITS_SW-1:0] sw_clean,
   output logic [NBITS_SW-1:0] sw_rise,
   output logic                tick
);

   localparam int            PW       = width_min1(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [NBITS_SW-1:0] w_rise_next;
   logic [NBITS_SW-1:0] rise_q;
   logic [PW-1:0]       pre_q;
   logic [PW-1:0]       pre_d;
   logic                tick_q;
   logic                tick_d;

   for (genvar i = 0; i < NBITS_SW; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk_i       (clk_2),
         .rst_ni      (reset_n),
         .raw_i       (sw_raw[i]),
         .clean_o     (sw_clean[i]),
         .rise_next_o (w_rise_next[i])
      );
   end

   // A clear being accepted restarts the tick phase even while frozen.
   always_comb begin
      pre_d  = pre_q;
      tick_d = 1'b0;
      if (w_rise_next[SW_CLEAR]) begin
         pre_d = '0;
      end else if (sw_clean[SW_FREEZE]) begin
         pre_d = pre_q;
      end else if (pre_q == PRE_LAST) begin
         pre_d  = '0;
         tick_d = 1'b1;
      end else begin
         pre_d = pre_q + PW'(1);
      end
   end

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         rise_q <= '0;
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         rise_q <= w_rise_next;
         pre_q  <= pre_d;
         tick_q <= tick_d;
      end
   end

   assign sw_rise = rise_q;
   assign tick    = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_condicionador_chaves.sv
// ============================================================================
// tb_condicionador_chaves : directed and random stimulus against a reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_condicionador_chaves;

   localparam int NB = 5;
   localparam int DC = 4;
   localparam int TD = 4;

   logic          clk_2   = 1'b0;
   logic          reset_n = 1'b1;
   logic [NB-1:0] sw_raw  = '0;
   logic [NB-1:0] sw_clean;
   logic [NB-1:0] sw_rise;
   logic          tick;

   int checks = 0;
   int errors = 0;

   // Reference state: raw delayed two samples, history of synchronised samples,
   // and a count of un-frozen cycles since the last reset or clear.
   logic [NB-1:0] m_sync1, m_sync2, m_clean, m_rise;
   logic          m_tick;
   int            act;
   logic [NB-1:0] hist[$];

   condicionador_chaves #(
      .NBITS_SW        (NB),
      .DEBOUNCE_CYCLES (DC),
      .TICK_DIV        (TD)
   ) dut (
      .clk_2    (clk_2),
      .reset_n  (reset_n),
      .sw_raw   (sw_raw),
      .sw_clean (sw_clean),
      .sw_rise  (sw_rise),
      .tick     (tick)
   );

   always #5 clk_2 = ~clk_2;

   function automatic void model_reset();
      m_sync1 = '0;
      m_sync2 = '0;
      m_clean = '0;
      m_rise  = '0;
      m_tick  = 1'b0;
      act     = 0;
      hist.delete();
      for (int k = 0; k < DC; k++) hist.push_back('0);
   endfunction

   // A bit flips once its last DC synchronised samples all disagree with it.
   function automatic void model_edge(input logic [NB-1:0] r);
      logic [NB-1:0] new_clean;
      logic [NB-1:0] rise;
      logic          differ;
      hist.push_back(m_sync2);
      if (hist.size() > DC) void'(hist.pop_front());
      new_clean = m_clean;
      rise      = '0;
      for (int i = 0; i < NB; i++) begin
         differ = 1'b1;
         foreach (hist[k]) if (hist[k][i] == m_clean[i]) differ = 1'b0;
         if (differ) begin
            new_clean[i] = ~m_clean[i];
            rise[i]      = ~m_clean[i];
         end
      end
      if (rise[0]) begin
         act    = 0;
         m_tick = 1'b0;
      end else if (m_clean[3]) begin
         m_tick = 1'b0;
      end else begin
         act    = act + 1;
         m_tick = ((act % TD) == 0);
      end
      m_clean = new_clean;
      m_rise  = rise;
      m_sync2 = m_sync1;
      m_sync1 = r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cycle(input logic [NB-1:0] r);
      sw_raw = r;
      @(posedge clk_2);
      model_edge(r);
      #1;
      check("sw_clean", 32'(sw_clean), 32'(m_clean));
      check("sw_rise",  32'(sw_rise),  32'(m_rise));
      check("tick",     32'(tick),     32'(m_tick));
      @(negedge clk_2);
   endtask

   task automatic hold(input logic [NB-1:0] r, input int n);
      for (int k = 0; k < n; k++) cycle(r);
   endtask

   // Reset asserted between edges must clear outputs without a clock edge.
   task automatic async_reset(input int hold_cycles);
      @(posedge clk_2);
      #2 reset_n = 1'b0;
      #1;
      check("rst_clean", 32'(sw_clean), 32'd0);
      check("rst_rise",  32'(sw_rise),  32'd0);
      check("rst_tick",  32'(tick),     32'd0);
      model_reset();
      repeat (hold_cycles) @(negedge clk_2);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [NB-1:0] r;
      int            idx;

      model_reset();
      @(negedge clk_2);
      async_reset(2);

      // Idle after reset: ticks every TD cycles.
      hold('0, 13);

      // Down switch step and hold.
      hold(5'b00010, 8);

      // Short step-3 glitch is rejected.
      hold(5'b00110, 3);
      hold(5'b00010, 8);

      // Freeze for a while, then release.
      hold(5'b01010, 16);
      hold(5'b00010, 12);

      // Clear restart, then clear together with freeze.
      hold(5'b00011, 10);
      hold(5'b00010, 8);
      hold(5'b01011, 12);
      hold(5'b00010, 12);

      // Reset mid-debounce of saturate, then hold it through the full latency.
      hold(5'b10010, 4);
      async_reset(3);
      hold(5'b10010, 10);
      hold(5'b00000, 8);

      // Random switching with mixed hold lengths, one reset in the middle.
      r = '0;
      for (int n = 0; n < 700; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            idx    = $urandom_range(0, NB - 1);
            r[idx] = ~r[idx];
         end
         if (n == 350) async_reset($urandom_range(1, 3));
         cycle(r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
